// File: rtl/flow_token_sched.sv
// Per-flow token-bucket scheduler: refills byte buckets each period and offers one
// packet task at a time, round-robin. Optional counters: FLOW_TOKEN_SCHED_STATS_EN.
module flow_token_sched #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int UPDATE_PERIOD  = 100,
  parameter int SIZE_WIDTH     = 16,
  parameter int TOKEN_WIDTH    = 32,
  parameter int BUCKET_WIDTH   = TOKEN_WIDTH + 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] wr_size_addr_i,
  input  logic [SIZE_WIDTH-1:0]     wr_size_data_i,
  input  logic                      wr_size_wr_en_i,
  input  logic [FLOW_CNT_WIDTH-1:0] wr_token_addr_i,
  input  logic [TOKEN_WIDTH-1:0]    wr_token_data_i,
  input  logic                      wr_token_wr_en_i,
  input  logic [FLOW_CNT_WIDTH-1:0] wr_flow_en_addr_i,
  input  logic                      wr_flow_en_data_i,
  input  logic                      wr_flow_en_wr_en_i,
  output logic                      task_valid_o,
  output logic [FLOW_CNT_WIDTH-1:0] task_flow_o,
  output logic [SIZE_WIDTH-1:0]     task_size_o,
  input  logic                      task_ready_i
`ifdef FLOW_TOKEN_SCHED_STATS_EN
  ,
  input  logic [FLOW_CNT_WIDTH-1:0] stat_addr_i,
  output logic [31:0]               stat_pkt_cnt_o
`endif
);

  localparam int PCW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SIZE_WIDTH-1:0]     size_tbl  [FLOW_CNT];
  logic [TOKEN_WIDTH-1:0]    token_tbl [FLOW_CNT];
  logic [FLOW_CNT-1:0]       en_tbl;
  logic [BUCKET_WIDTH-1:0]   bucket_q  [FLOW_CNT];
  logic [BUCKET_WIDTH-1:0]   bucket_d  [FLOW_CNT];
  logic [FLOW_CNT_WIDTH-1:0] rr_ptr;
  logic [PCW-1:0]            period_cnt;
  logic                      refill;
  logic [FLOW_CNT-1:0]       elig;
  logic                      any_elig;
  logic [FLOW_CNT_WIDTH-1:0] pick;
  logic                      hs;

  // Handshake: a task transfers on a clock edge where task_valid_o and task_ready_i
  // are both high; valid, flow and size are held unchanged until that edge.

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
        size_tbl[i]  <= '0;
        token_tbl[i] <= '0;
      end
      en_tbl <= '0;
    end else begin
      if (wr_size_wr_en_i)    size_tbl[wr_size_addr_i]   <= wr_size_data_i;
      if (wr_token_wr_en_i)   token_tbl[wr_token_addr_i] <= wr_token_data_i;
      if (wr_flow_en_wr_en_i) en_tbl[wr_flow_en_addr_i]  <= wr_flow_en_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                      period_cnt <= '0;
    else if (period_cnt == PCW'(UPDATE_PERIOD - 1)) period_cnt <= '0;
    else                                            period_cnt <= period_cnt + 1'b1;
  end

  assign refill = (period_cnt == PCW'(UPDATE_PERIOD - 1));

  // Refill and debit combine in one step; the cap only applies when tokens are added.
  always_comb begin
    logic [BUCKET_WIDTH-1:0] debit;
    logic [BUCKET_WIDTH-1:0] sum;
    logic [BUCKET_WIDTH-1:0] cap;
    logic [BUCKET_WIDTH-1:0] net;
    debit = '0;
    sum   = '0;
    cap   = '0;
    net   = '0;
    for (int i = 0; i < FLOW_CNT; i++) begin
      debit = (hs && task_flow_o == FLOW_CNT_WIDTH'(i)) ? BUCKET_WIDTH'(task_size_o) : '0;
      sum   = bucket_q[i] + (refill ? BUCKET_WIDTH'(token_tbl[i]) : '0);
      cap   = BUCKET_WIDTH'(token_tbl[i]) + BUCKET_WIDTH'(size_tbl[i]);
      net   = (sum >= debit) ? sum - debit : '0;
      if (!en_tbl[i])              bucket_d[i] = '0;
      else if (refill && net > cap) bucket_d[i] = cap;
      else                          bucket_d[i] = net;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) bucket_q[i] <= '0;
    end else begin
      for (int i = 0; i < FLOW_CNT; i++) bucket_q[i] <= bucket_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < FLOW_CNT; i++) begin
      elig[i] = en_tbl[i] && (size_tbl[i] != '0) &&
                (bucket_q[i] >= BUCKET_WIDTH'(size_tbl[i]));
    end
  end

  assign any_elig = |elig;

  // First eligible flow at or above rr_ptr, wrapping past the top index.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < FLOW_CNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= FLOW_CNT) idx = idx - FLOW_CNT;
      if (!found && elig[FLOW_CNT_WIDTH'(idx)]) begin
        found = 1'b1;
        pick  = FLOW_CNT_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig)     state_d = OFFER;
      OFFER:   if (task_ready_i) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    task_valid_o = (state_q == OFFER);
    hs           = (state_q == OFFER) && task_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      task_flow_o <= '0;
      task_size_o <= '0;
    end else if (state_q == IDLE && any_elig) begin
      task_flow_o <= pick;
      task_size_o <= size_tbl[pick];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                              rr_ptr <= '0;
    else if (hs && task_flow_o == FLOW_CNT_WIDTH'(FLOW_CNT - 1)) rr_ptr <= '0;
    else if (hs)                                            rr_ptr <= task_flow_o + 1'b1;
  end

`ifdef FLOW_TOKEN_SCHED_STATS_EN
  logic [31:0] pkt_cnt [FLOW_CNT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) pkt_cnt[i] <= '0;
      stat_pkt_cnt_o <= '0;
    end else begin
      if (hs) pkt_cnt[task_flow_o] <= pkt_cnt[task_flow_o] + 32'd1;
      stat_pkt_cnt_o <= pkt_cnt[stat_addr_i];
    end
  end
`else
  // Build without per-flow packet counters.
`endif

endmodule
